// File: rtl/blit_mem_pkg.sv
// Shared types and constants for the blitter/display SDRAM port arbiter.
package blit_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    BURST   = 2'd2
  } arb_state_e;

  localparam int ADDR_W       = 26;
  localparam int NUM_PORTS    = 3;
  localparam int BURST_WORDS  = 8;
  localparam int PORT_DISPLAY = 0;
  localparam int PORT_BLIT_RD = 1;
  localparam int PORT_BLIT_WR = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, one-hot out.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  request,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick
);

  localparam logic [PW:0] NUM_L = (PW+1)'(N);

  logic [PW:0]   sum_s;
  logic [PW-1:0] idx_s;
  logic          found_s;

  // Scan N positions starting at ptr, wrapping modulo N.
  always_comb begin
    pick    = '0;
    found_s = 1'b0;
    sum_s   = '0;
    idx_s   = '0;
    for (int off = 0; off < N; off++) begin
      sum_s = {1'b0, ptr} + (PW+1)'(off);
      if (sum_s >= NUM_L) begin
        sum_s = sum_s - NUM_L;
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[PW-1:0];
      if (!found_s && request[idx_s]) begin
        pick[idx_s] = 1'b1;
        found_s     = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/blit_mem_arbiter.sv
// One-at-a-time arbiter of the SDRAM burst port between display, blit read and blit write.
// Optional: BLIT_ARB_DISPLAY_PRIORITY_EN gives port 0 absolute priority in IDLE arbitration.
module blit_mem_arbiter #(
  parameter int NUM_PORTS = blit_mem_pkg::NUM_PORTS,
  parameter int ADDR_W    = blit_mem_pkg::ADDR_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_request,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_address,
  input  logic [NUM_PORTS*32-1:0]     req_wdata,
  input  logic [NUM_PORTS*4-1:0]      req_wmask,
  output logic [NUM_PORTS-1:0]        req_ack,
  output logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_complete,
  output logic [31:0]                 req_rdata,
  output logic                        mem_request,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [31:0]                 mem_wdata,
  output logic [3:0]                  mem_wmask,
  input  logic                        mem_ack,
  input  logic                        mem_valid,
  input  logic                        mem_complete,
  input  logic [31:0]                 mem_data,
  output logic [NUM_PORTS-1:0]        grant,
  output logic                        protocol_error
);
  import blit_mem_pkg::*;

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_e           state_q;
  logic [NUM_PORTS-1:0] grant_q;
  logic [PW-1:0]        winner_q;
  logic [PW-1:0]        rr_ptr_q;
  logic                 mem_request_q;
  logic                 mem_write_q;
  logic [ADDR_W-1:0]    mem_address_q;
  logic [31:0]          mem_wdata_q;
  logic [3:0]           mem_wmask_q;
  logic                 protocol_error_q;

  logic [NUM_PORTS-1:0] rr_req_s;
  logic [NUM_PORTS-1:0] pick_s;
  logic [NUM_PORTS-1:0] win_oh_s;
  logic [PW-1:0]        win_idx_s;
  logic                 win_write_s;
  logic [ADDR_W-1:0]    win_addr_s;
  logic [31:0]          win_wdata_s;
  logic [3:0]           win_wmask_s;
  logic [PW-1:0]        rr_ptr_d;
  logic                 in_req_s;
  logic                 in_burst_s;
  logic                 done_s;
  logic                 proto_err_s;

  rr_pick #(.N(NUM_PORTS), .PW(PW)) u_rr_pick (
    .request (rr_req_s),
    .ptr     (rr_ptr_q),
    .pick    (pick_s)
  );

  // Winner selection, with optional display override ahead of the round-robin.
  always_comb begin
`ifdef BLIT_ARB_DISPLAY_PRIORITY_EN
    rr_req_s = req_request;
    rr_req_s[PORT_DISPLAY] = 1'b0;
    if (req_request[PORT_DISPLAY]) begin
      win_oh_s = '0;
      win_oh_s[PORT_DISPLAY] = 1'b1;
    end else begin
      win_oh_s = pick_s;
    end
`else
    rr_req_s = req_request;
    win_oh_s = pick_s;
`endif
  end

  // Decode the one-hot winner into its index and request fields.
  always_comb begin
    win_idx_s   = '0;
    win_write_s = 1'b0;
    win_addr_s  = '0;
    win_wdata_s = '0;
    win_wmask_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (win_oh_s[i]) begin
        win_idx_s   = PW'(i);
        win_write_s = req_write[i];
        win_addr_s  = req_address[i*ADDR_W +: ADDR_W];
        win_wdata_s = req_wdata[i*32 +: 32];
        win_wmask_s = req_wmask[i*4 +: 4];
      end else begin
        win_idx_s = win_idx_s;
      end
    end
  end

  // Pointer advance after a transaction; display wins never move it in priority mode.
  always_comb begin
`ifdef BLIT_ARB_DISPLAY_PRIORITY_EN
    if (winner_q == PW'(PORT_DISPLAY)) begin
      rr_ptr_d = rr_ptr_q;
    end else if (winner_q == PW'(NUM_PORTS-1)) begin
      rr_ptr_d = PW'(1);
    end else begin
      rr_ptr_d = winner_q + PW'(1);
    end
`else
    if (winner_q == PW'(NUM_PORTS-1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = winner_q + PW'(1);
    end
`endif
  end

  assign in_req_s    = (state_q == REQUEST);
  assign in_burst_s  = (state_q == BURST);
  // An ack arriving with its complete finishes the transaction from REQUEST.
  assign done_s      = mem_complete & (in_burst_s | (in_req_s & mem_ack));
  assign proto_err_s = (mem_ack & ~in_req_s) | (mem_valid & ~in_burst_s) |
                       (mem_complete & ~(in_burst_s | (in_req_s & mem_ack)));

  // Arbiter FSM and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      grant_q          <= '0;
      winner_q         <= '0;
      rr_ptr_q         <= '0;
      mem_request_q    <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_wdata_q      <= '0;
      mem_wmask_q      <= '0;
      protocol_error_q <= 1'b0;
    end else begin
      protocol_error_q <= protocol_error_q | proto_err_s;
      case (state_q)
        IDLE: begin
          if (|req_request) begin
            grant_q       <= win_oh_s;
            winner_q      <= win_idx_s;
            mem_write_q   <= win_write_s;
            mem_address_q <= win_addr_s;
            mem_wdata_q   <= win_wdata_s;
            mem_wmask_q   <= win_wmask_s;
            mem_request_q <= 1'b1;
            state_q       <= REQUEST;
          end
        end
        REQUEST: begin
          if (mem_ack) begin
            mem_request_q <= 1'b0;
            if (mem_complete) begin
              grant_q  <= '0;
              rr_ptr_q <= rr_ptr_d;
              state_q  <= IDLE;
            end else begin
              state_q <= BURST;
            end
          end
        end
        BURST: begin
          if (mem_complete) begin
            grant_q  <= '0;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= IDLE;
          end
        end
        default: begin
          grant_q       <= '0;
          mem_request_q <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign req_ack        = grant_q & {NUM_PORTS{in_req_s & mem_ack}};
  assign req_valid      = grant_q & {NUM_PORTS{in_burst_s & mem_valid}};
  assign req_complete   = grant_q & {NUM_PORTS{done_s}};
  assign req_rdata      = mem_data;
  assign mem_request    = mem_request_q;
  assign mem_write      = mem_write_q;
  assign mem_address    = mem_address_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_wmask      = mem_wmask_q;
  assign grant          = grant_q;
  assign protocol_error = protocol_error_q;

endmodule

// File: tb/tb_blit_mem_arbiter.sv
// Directed self-checking bench for blit_mem_arbiter.
module tb_blit_mem_arbiter;

  localparam int NP = 3;
  localparam int AW = 26;

  logic              clock = 1'b0;
  logic              reset;
  logic [NP-1:0]     req_request, req_write;
  logic [NP*AW-1:0]  req_address;
  logic [NP*32-1:0]  req_wdata;
  logic [NP*4-1:0]   req_wmask;
  logic [NP-1:0]     req_ack, req_valid, req_complete, grant;
  logic [31:0]       req_rdata, mem_wdata, mem_data;
  logic              mem_request, mem_write, mem_ack, mem_valid, mem_complete;
  logic              protocol_error;
  logic [AW-1:0]     mem_address;
  logic [3:0]        mem_wmask;

  int compared   = 0;
  int mismatched = 0;

  blit_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .req_request(req_request), .req_write(req_write), .req_address(req_address),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .req_ack(req_ack), .req_valid(req_valid), .req_complete(req_complete),
    .req_rdata(req_rdata),
    .mem_request(mem_request), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ack(mem_ack), .mem_valid(mem_valid), .mem_complete(mem_complete),
    .mem_data(mem_data),
    .grant(grant), .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int vcount;
  int ccount;
  int order [4];
  logic [AW-1:0] addr_tab [3];

  initial begin
    reset = 1'b1; req_request = '0; req_write = '0; req_address = '0;
    req_wdata = '0; req_wmask = '0;
    mem_ack = 1'b0; mem_valid = 1'b0; mem_complete = 1'b0; mem_data = '0;
    addr_tab[0] = 26'h0000100; addr_tab[1] = 26'h0002200; addr_tab[2] = 26'h0003300;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_mem_request", 64'(mem_request), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_mem_address", 64'(mem_address), 64'd0);
    chk("rst_protocol_error", 64'(protocol_error), 64'd0);
    chk("rst_mem_wmask", 64'(mem_wmask), 64'd0);

    // Port 1 read burst
    req_request = 3'b010;
    req_address[1*AW +: AW] = 26'h0001240;
    tick();
    chk("rd_mem_request", 64'(mem_request), 64'd1);
    chk("rd_grant", 64'(grant), 64'h2);
    chk("rd_mem_address", 64'(mem_address), 64'h1240);
    chk("rd_mem_write", 64'(mem_write), 64'd0);
    tick(); tick();
    chk("rd_hold_request", 64'(mem_request), 64'd1);
    mem_ack = 1'b1;
    #1;
    chk("rd_req_ack", 64'(req_ack), 64'h2);
    tick();
    mem_ack = 1'b0;
    req_request = 3'b000;
    #1;
    chk("rd_request_dropped", 64'(mem_request), 64'd0);
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      mem_valid = 1'b1;
      mem_data = 32'hA000_0000 + 32'(i);
      #1;
      if (req_valid == 3'b010) vcount++;
      tick();
    end
    mem_valid = 1'b0;
    chk("rd_rdata", 64'(req_rdata), 64'hA000_0007);
    chk("rd_valid_count", 64'(vcount), 64'd8);
    mem_complete = 1'b1;
    #1;
    chk("rd_req_complete", 64'(req_complete), 64'h2);
    tick();
    mem_complete = 1'b0;
    #1;
    chk("rd_grant_idle", 64'(grant), 64'd0);
    chk("rd_no_proto_err", 64'(protocol_error), 64'd0);

    // Port 2 write, ack and complete together
    req_request = 3'b100;
    req_write = 3'b100;
    req_wdata[2*32 +: 32] = 32'hDEADBEEF;
    req_wmask[2*4 +: 4] = 4'b0011;
    req_address[2*AW +: AW] = 26'h0000040;
    tick();
    chk("wr_grant", 64'(grant), 64'h4);
    chk("wr_mem_write", 64'(mem_write), 64'd1);
    chk("wr_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    chk("wr_mem_wmask", 64'(mem_wmask), 64'h3);
    mem_ack = 1'b1; mem_complete = 1'b1;
    #1;
    chk("wr_req_ack", 64'(req_ack), 64'h4);
    chk("wr_req_complete", 64'(req_complete), 64'h4);
    tick();
    mem_ack = 1'b0; mem_complete = 1'b0;
    req_request = 3'b000; req_write = 3'b000;
    #1;
    chk("wr_idle_grant", 64'(grant), 64'd0);
    chk("wr_idle_request", 64'(mem_request), 64'd0);
    chk("wr_no_proto_err", 64'(protocol_error), 64'd0);

    // All ports requesting continuously from reset
`ifdef BLIT_ARB_DISPLAY_PRIORITY_EN
    order[0] = 0; order[1] = 0; order[2] = 0; order[3] = 0;
`else
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int p = 0; p < NP; p++) req_address[p*AW +: AW] = addr_tab[p];
    req_request = 3'b111;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_grant_%0d", k), 64'(grant), 64'(3'b001 << order[k]));
      chk($sformatf("rr_addr_%0d", k), 64'(mem_address), 64'(addr_tab[order[k]]));
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      mem_complete = 1'b1;
      tick();
      mem_complete = 1'b0;
      #1;
      chk($sformatf("rr_dead_%0d", k), 64'({grant, mem_request}), 64'd0);
      tick();
    end
    req_request = 3'b000;

    // Stray mem_valid while idle
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_valid = 1'b1;
    #1;
    chk("pe_no_req_valid", 64'(req_valid), 64'd0);
    tick();
    mem_valid = 1'b0;
    #1;
    chk("pe_set", 64'(protocol_error), 64'd1);
    tick(); tick();
    chk("pe_sticky", 64'(protocol_error), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("pe_reset_clear", 64'(protocol_error), 64'd0);

    // Reset mid-burst, then a fresh request
    req_request = 3'b010;
    req_address[1*AW +: AW] = 26'h0000800;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    req_request = 3'b000;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1;
      tick();
    end
    mem_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mr_mem_request", 64'(mem_request), 64'd0);
    chk("mr_grant", 64'(grant), 64'd0);
    req_request = 3'b010;
    req_address[1*AW +: AW] = 26'h0000C00;
    tick();
    chk("mr_regrant", 64'(grant), 64'h2);
    chk("mr_mem_request2", 64'(mem_request), 64'd1);
    chk("mr_address", 64'(mem_address), 64'hC00);
    mem_ack = 1'b1; mem_complete = 1'b1;
    #1;
    ccount = (req_complete == 3'b010) ? 1 : 0;
    tick();
    mem_ack = 1'b0; mem_complete = 1'b0; req_request = 3'b000;
    #1;
    chk("mr_complete_seen", 64'(ccount), 64'd1);
    chk("mr_done_idle", 64'(grant), 64'd0);
    chk("mr_no_proto_err", 64'(protocol_error), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/blit_mem_arbiter.md
# blit_mem_arbiter

Shares the single SDRAM burst port between the blitter read cache, the blitter pixel write path and the display fetch unit. Each requester sees the same request/ack/valid/complete handshake it would see from the SDRAM controller directly. The arbiter grants one transaction at a time and routes the memory handshake back to the winner. It sits between the blitter/display clients and the SDRAM controller.

## Interface
- NUM_PORTS, 3, number of requesters; port 0 display, 1 blit read cache, 2 blit write
- ADDR_W, 26, memory byte-address width
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- req_request  in  NUM_PORTS  per-port request level; held until that port's req_ack
- req_write  in  NUM_PORTS  1 = single-word write, 0 = 8-word read burst
- req_address  in  NUM_PORTS*ADDR_W  per-port address, port i at bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_PORTS*32  per-port write data
- req_wmask  in  NUM_PORTS*4  per-port byte enables
- req_ack  out  NUM_PORTS  one-hot pulse to granted port when mem_ack arrives
- req_valid  out  NUM_PORTS  one-hot; mem_valid routed to granted port
- req_complete  out  NUM_PORTS  one-hot; mem_complete routed to granted port
- req_rdata  out  32  mem_data broadcast to all ports
- mem_request  out  1  request to SDRAM controller
- mem_write  out  1  registered req_write of winner
- mem_address  out  ADDR_W  registered winner address
- mem_wdata  out  32  registered winner write data
- mem_wmask  out  4  registered winner byte enables
- mem_ack, mem_valid, mem_complete  in  1 each  SDRAM controller handshake
- mem_data  in  32  SDRAM read data
- grant  out  NUM_PORTS  one-hot current owner, 0 when idle
- protocol_error  out  1  sticky; set on any unexpected mem handshake

## Operation
- States: IDLE, REQUEST, BURST.
- IDLE: if any req_request is set, pick the winner round-robin, starting search at rr_ptr. Register the winner's address, write, wdata and wmask into mem_*. Set grant and mem_request=1. Go to REQUEST.
- REQUEST: hold mem_request and mem_* stable. On mem_ack: mem_request<=0, req_ack[winner]=1 that cycle (combinational from mem_ack), go to BURST. If mem_complete arrives in the same cycle as mem_ack, go straight to IDLE.
- BURST: req_valid[winner]=mem_valid and req_complete[winner]=mem_complete, both combinational. On mem_complete: grant<=0, rr_ptr<=winner+1 (wraps at NUM_PORTS-1 -> 0), go to IDLE.
- Ungranted ports see req_ack, req_valid and req_complete at 0 at all times.
- The arbiter does not re-sample req_request after granting. A request dropped after grant still completes, and its result is discarded by the client.
- protocol_error is set by any of: mem_ack outside REQUEST; mem_valid or mem_complete outside BURST (except the REQUEST ack+complete case above); mem_valid in REQUEST. The offending input is otherwise ignored.

## Timing
- Reset values: mem_request 0, mem_write 0, mem_address 0, mem_wdata 0, mem_wmask 0, grant 0, rr_ptr 0, protocol_error 0, state IDLE. req_ack/req_valid/req_complete are 0 when grant is 0.
- Reset mid-transaction abandons it immediately. The SDRAM controller shares the same reset.
- Arbitration latency: req_request high in cycle N (state IDLE) gives mem_request high in N+1.
- Back-to-back: mem_complete in cycle N gives IDLE in N+1 and the next mem_request in N+2, i.e. one dead cycle minimum.
- Routed req_* outputs add zero cycles of latency.

## Configuration
- BLIT_ARB_DISPLAY_PRIORITY_EN defined: port 0 wins any IDLE arbitration in which it requests, regardless of rr_ptr; rr_ptr still rotates among ports 1..NUM_PORTS-1.
- BLIT_ARB_DISPLAY_PRIORITY_EN undefined: pure round-robin over all ports.

## Structure
- Package blit_mem_pkg: state enum (IDLE/REQUEST/BURST), ADDR_W, BURST_WORDS=8, port index constants PORT_DISPLAY/PORT_BLIT_RD/PORT_BLIT_WR.
- One sub-module, rr_pick: combinational round-robin one-hot picker (inputs request vector and rr_ptr, output one-hot). The priority override is applied in the parent.

## Test plan
- Port 1 read at 0x0001240, controller acks after 2 cycles then gives 8 valids and complete -> mem_address=0x0001240, mem_write=0, exactly 8 req_valid[1] pulses, req_complete[1] once, grant returns to 0.
- Ports 0, 1 and 2 all request continuously from reset -> grant order 0,1,2,0 with one idle cycle between transactions.
- With BLIT_ARB_DISPLAY_PRIORITY_EN defined, ports 0 and 2 requesting continuously -> port 0 wins every arbitration.
- Port 2 write, wdata=0xDEADBEEF, wmask=4'b0011, controller asserts mem_ack and mem_complete in the same cycle -> one req_ack[2] and one req_complete[2] pulse, state back to IDLE next cycle.
- mem_valid pulsed while IDLE -> protocol_error=1 and stays 1, no req_valid asserted; reset clears it to 0.
- Reset asserted in BURST after 3 valids -> next cycle mem_request=0, grant=0; a fresh port 1 request afterwards is granted normally.
